// File: rtl/arb_pkg.sv
// Shared constants and helpers for the round-robin arbiter family.
// Width rules and the channel slice helper live here so every arbiter agrees on them.
package arb_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_N_CH   = 3;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // A channel index is never narrower than one bit, even for N_CH=1.
  function automatic int sel_w(input int n);
    return (n <= 1) ? 1 : clog2(n);
  endfunction

  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/arb_rr_n_if.sv
// Sink/source handshake bundle of the N-channel round-robin arbiter.
// ARB_PKT_LOCK_EN adds the per-channel and source packet-last signals.
interface arb_rr_n_if
  import arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int N_CH   = DEF_N_CH
);
  localparam int SEL_W = sel_w(N_CH);

  logic [N_CH*DATA_W-1:0] iSnkData;
  logic [N_CH-1:0]        iSnkValid;
  logic [N_CH-1:0]        oSnkReady;
  logic [DATA_W-1:0]      oSrc0Data;
  logic                   oSrc0Valid;
  logic                   iSrc0Ready;
  logic [SEL_W-1:0]       oSrc0Sel;
`ifdef ARB_PKT_LOCK_EN
  logic [N_CH-1:0]        iSnkLast;
  logic                   oSrc0Last;

  modport slave (
    input  iSnkData, iSnkValid, iSnkLast, iSrc0Ready,
    output oSnkReady, oSrc0Data, oSrc0Valid, oSrc0Sel, oSrc0Last
  );
  modport master (
    output iSnkData, iSnkValid, iSnkLast, iSrc0Ready,
    input  oSnkReady, oSrc0Data, oSrc0Valid, oSrc0Sel, oSrc0Last
  );
`else
  modport slave (
    input  iSnkData, iSnkValid, iSrc0Ready,
    output oSnkReady, oSrc0Data, oSrc0Valid, oSrc0Sel
  );
  modport master (
    output iSnkData, iSnkValid, iSrc0Ready,
    input  oSnkReady, oSrc0Data, oSrc0Valid, oSrc0Sel
  );
`endif

endinterface

// File: rtl/arb_rr_pick.sv
// Combinational round-robin picker: first requester after ptr, wrapping.
// Shared by single- and multi-source arbiters.
module arb_rr_pick
  import arb_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int SEL_W = sel_w(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N_CH-1:0]  gnt_onehot,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             any
);

  always_comb begin
    int c;
    c          = 0;
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    // Offset N_CH lands back on ptr itself, so it is searched last.
    for (int off = 1; off <= N_CH; off++) begin
      c = (int'(ptr) + off) % N_CH;
      if (!any && req[c]) begin
        any           = 1'b1;
        gnt_onehot[c] = 1'b1;
        gnt_idx       = SEL_W'(c);
      end
    end
  end

endmodule

// File: rtl/arb_rr_n.sv
// N-sink to 1-source round-robin arbiter with a registered output slice.
// Define ARB_PKT_LOCK_EN to hold the grant on a channel until its last beat.
module arb_rr_n
  import arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int N_CH   = DEF_N_CH
) (
  input logic        clk,
  input logic        rst,
  arb_rr_n_if.slave  bus
);

  localparam int SEL_W = sel_w(N_CH);

  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              valid_q, valid_d;

  logic              load;
  logic [N_CH-1:0]   req;
  logic [N_CH-1:0]   gnt_oh;
  logic [SEL_W-1:0]  gnt_idx;
  logic              any;

`ifdef ARB_PKT_LOCK_EN
  logic lock_q, lock_d;
  logic last_q, last_d;

  // While locked ptr_q is the locked channel, so only its request survives.
  always_comb begin
    req = bus.iSnkValid;
    if (lock_q) req = bus.iSnkValid & (N_CH'(1) << ptr_q);
  end
`else
  always_comb req = bus.iSnkValid;
`endif

  arb_rr_pick #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_pick (
    .req        (req),
    .ptr        (ptr_q),
    .gnt_onehot (gnt_oh),
    .gnt_idx    (gnt_idx),
    .any        (any)
  );

  always_comb begin
    load  = !valid_q || bus.iSrc0Ready;
    ptr_d   = ptr_q;
    data_d  = data_q;
    sel_d   = sel_q;
    valid_d = valid_q;
`ifdef ARB_PKT_LOCK_EN
    lock_d  = lock_q;
    last_d  = last_q;
`endif
    if (load) begin
      if (any) begin
        data_d  = bus.iSnkData[slice_lo(int'(gnt_idx), DATA_W) +: DATA_W];
        sel_d   = gnt_idx;
        valid_d = 1'b1;
        ptr_d   = gnt_idx;
`ifdef ARB_PKT_LOCK_EN
        last_d  = bus.iSnkLast[gnt_idx];
        lock_d  = !bus.iSnkLast[gnt_idx];
`endif
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= SEL_W'(N_CH - 1);
      data_q  <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
`ifdef ARB_PKT_LOCK_EN
      lock_q  <= 1'b0;
      last_q  <= 1'b0;
`endif
    end else begin
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
`ifdef ARB_PKT_LOCK_EN
      lock_q  <= lock_d;
      last_q  <= last_d;
`endif
    end
  end

  // No sink may see ready while reset is held.
  assign bus.oSnkReady  = (rst || !load) ? '0 : gnt_oh;
  assign bus.oSrc0Data  = data_q;
  assign bus.oSrc0Valid = valid_q;
  assign bus.oSrc0Sel   = sel_q;
`ifdef ARB_PKT_LOCK_EN
  assign bus.oSrc0Last  = last_q;
`endif

endmodule

// File: tb/tb_arb_rr_n.sv
// Bench for arb_rr_n: directed scenarios then randomized traffic,
// checked against a rotation-rule reference model.
module tb_arb_rr_n;
  import arb_pkg::*;

  localparam int DW = 32;
  localparam int N  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  arb_rr_n_if #(.DATA_W(DW), .N_CH(N)) bus ();

  arb_rr_n #(
    .DATA_W (DW),
    .N_CH   (N)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int          m_ptr   = N - 1;
  bit          m_valid = 1'b0;
  logic [DW-1:0] m_data = '0;
  int          m_sel   = 0;
  bit          m_lock  = 1'b0;
  bit          m_last  = 1'b0;
  logic [N-1:0] acc    = '0;
  int          a       = 0;

  function automatic int ref_grant(input logic [N-1:0] v, input int p);
    for (int off = 1; off <= N; off++) begin
      int c;
      c = (p + off) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_ch(input int i, input bit v, input int val);
    bus.iSnkValid[i] = v;
    bus.iSnkData[i*DW +: DW] = DW'(val) << (2 * i);
  endtask

  task automatic drive_all(input bit v, input int val);
    for (int i = 0; i < N; i++) drive_ch(i, v, val);
  endtask

  // Check at the falling edge, advance the model, return just after the rise.
  task automatic step();
    logic [N-1:0] v;
    logic [N-1:0] er;
    bit ld;
    int g;
    @(negedge clk);
    v = bus.iSnkValid;
`ifdef ARB_PKT_LOCK_EN
    if (m_lock) v &= (N'(1) << m_ptr);
`endif
    ld = !m_valid || bus.iSrc0Ready;
    g  = ref_grant(v, m_ptr);
    er = '0;
    if (!rst && ld && g >= 0) er[g] = 1'b1;
    chk("snk_ready", 64'(bus.oSnkReady), 64'(er));
    chk("src_valid", 64'(bus.oSrc0Valid), 64'(m_valid));
    chk("src_data", 64'(bus.oSrc0Data), 64'(m_data));
    chk("src_sel", 64'(bus.oSrc0Sel), 64'(m_sel));
`ifdef ARB_PKT_LOCK_EN
    chk("src_last", 64'(bus.oSrc0Last), 64'(m_last));
`endif
    acc = er;
    if (rst) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_sel   = 0;
      m_ptr   = N - 1;
      m_lock  = 1'b0;
      m_last  = 1'b0;
    end else if (ld) begin
      if (g >= 0) begin
        m_valid = 1'b1;
        m_data  = bus.iSnkData[g*DW +: DW];
        m_sel   = g;
        m_ptr   = g;
`ifdef ARB_PKT_LOCK_EN
        m_last  = bus.iSnkLast[g];
        m_lock  = !bus.iSnkLast[g];
`endif
      end else begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.iSnkData   = '0;
    bus.iSnkValid  = '0;
    bus.iSrc0Ready = 1'b1;
`ifdef ARB_PKT_LOCK_EN
    bus.iSnkLast   = '1;
`endif

    // Reset with all sinks offering: nothing may be accepted.
    rst = 1'b1;
    drive_all(1'b1, 9);
    repeat (4) step();
    rst = 1'b0;
    drive_all(1'b0, 0);

    // Single requester on channel 1, sustained.
    drive_ch(1, 1'b1, 5);
    step();
    chk("ch1_data", 64'(bus.oSrc0Data), 64'd20);
    chk("ch1_sel", 64'(bus.oSrc0Sel), 64'd1);
    for (int k = 6; k < 10; k++) begin
      drive_ch(1, 1'b1, k);
      step();
      chk("ch1_sus_data", 64'(bus.oSrc0Data), 64'(k << 2));
      chk("ch1_sus_sel", 64'(bus.oSrc0Sel), 64'd1);
    end

    // All channels from reset rotate 0,1,2 with no gaps.
    rst = 1'b1;
    drive_all(1'b0, 0);
    step();
    rst = 1'b0;
    drive_all(1'b1, 7);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rot_sel", 64'(bus.oSrc0Sel), 64'(k % 3));
      chk("rot_valid", 64'(bus.oSrc0Valid), 64'd1);
    end

    // Stall holding 0x10 from channel 1.
    drive_all(1'b0, 0);
    drive_ch(1, 1'b1, 4);
    step();
    chk("stall_load", 64'(bus.oSrc0Data), 64'h10);
    bus.iSrc0Ready = 1'b0;
    drive_ch(0, 1'b1, 1);
    drive_ch(1, 1'b1, 2);
    drive_ch(2, 1'b1, 3);
    repeat (3) begin
      step();
      chk("stall_data", 64'(bus.oSrc0Data), 64'h10);
      chk("stall_sel", 64'(bus.oSrc0Sel), 64'd1);
      chk("stall_rdy", 64'(bus.oSnkReady), 64'd0);
    end
    bus.iSrc0Ready = 1'b1;
    step();
    chk("post_stall_sel", 64'(bus.oSrc0Sel), 64'd2);

    // Reset pulse while the output holds a beat.
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_drop_valid", 64'(bus.oSrc0Valid), 64'd0);
    drive_all(1'b1, 11);
    step();
    chk("rst_next_sel", 64'(bus.oSrc0Sel), 64'd0);
    chk("rst_next_valid", 64'(bus.oSrc0Valid), 64'd1);

`ifdef ARB_PKT_LOCK_EN
    // Three-beat packet on channel 2 holds off channels 0 and 1.
    rst = 1'b1;
    drive_all(1'b0, 0);
    step();
    rst = 1'b0;
    drive_ch(2, 1'b1, 1);
    bus.iSnkLast = 3'b000;
    step();
    chk("pkt_sel0", 64'(bus.oSrc0Sel), 64'd2);
    drive_ch(0, 1'b1, 1);
    drive_ch(1, 1'b1, 1);
    drive_ch(2, 1'b1, 2);
    bus.iSnkLast = 3'b011;
    step();
    chk("pkt_sel1", 64'(bus.oSrc0Sel), 64'd2);
    chk("pkt_lock_rdy", 64'(bus.oSnkReady & 3'b011), 64'd0);
    drive_ch(2, 1'b1, 3);
    bus.iSnkLast = 3'b111;
    step();
    chk("pkt_sel2", 64'(bus.oSrc0Sel), 64'd2);
    chk("pkt_last", 64'(bus.oSrc0Last), 64'd1);
    drive_ch(2, 1'b0, 0);
    step();
    chk("pkt_after0", 64'(bus.oSrc0Sel), 64'd0);
    drive_ch(0, 1'b0, 0);
    step();
    chk("pkt_after1", 64'(bus.oSrc0Sel), 64'd1);
`endif

    // Randomized traffic; a sink holds its beat until accepted.
    drive_all(1'b0, 0);
    acc = '0;
    for (int t = 0; t < 400; t++) begin
      bus.iSrc0Ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < N; i++) begin
        if (!(bus.iSnkValid[i] && !acc[i])) begin
          a++;
          drive_ch(i, ($urandom_range(0, 2) != 0), a);
`ifdef ARB_PKT_LOCK_EN
          bus.iSnkLast[i] = ($urandom_range(0, 2) == 0);
`endif
        end
      end
      step();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
